// File: rtl/ram_dump_pkg.sv
// Shared types and width helpers for the data-RAM dump reader.
// clogb2 matches the ram_datos address-width calculation.
package ram_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_FIN   = 3'd4
    } dump_state_e;

    // Number of bits needed to hold 'depth'; clogb2(1023) = 10.
    function automatic int clogb2(input int depth);
        int d;
        int r;
        d = depth;
        r = 0;
        while (d > 0) begin
            d = d >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/ram_datos_dump_reader.sv
// Reads a run of words from the data RAM and streams them LSB-first as bytes
// over a valid/ready interface toward the debug-unit UART transmitter.
module ram_datos_dump_reader
    import ram_dump_pkg::*;
#(
    parameter int RAM_WIDTH    = 16,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 1,
    localparam int ADDR_W      = clogb2(RAM_DEPTH - 1)
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_count,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_en,
    input  logic [RAM_WIDTH-1:0] i_ram_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int NB     = nbytes(RAM_WIDTH);
    localparam int SH_W   = NB * 8;
    localparam int BIDX_W = clogb2(NB);
    localparam int LAT_W  = clogb2(READ_LATENCY);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(RAM_DEPTH);
    localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NB - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    dump_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic [SH_W-1:0]   shift_q;
    logic [BIDX_W-1:0] byte_q;
    logic [LAT_W-1:0]  wait_q;
    logic              busy_q;

    logic [ADDR_W:0]   count_clamped;
    logic [ADDR_W-1:0] addr_next;
    logic              xfer;
    logic              last_byte;
    logic              last_word;
    logic              lat_done;

    assign count_clamped = (i_count > DEPTH_C) ? DEPTH_C : i_count;
    // Explicit wrap so non-power-of-two depths return to word 0.
    assign addr_next     = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    assign xfer          = (state_q == ST_SEND) && i_tx_ready;
    assign last_byte     = (byte_q == LAST_BYTE);
    assign last_word     = (remain_q == ONE_WORD);
    assign lat_done      = (wait_q == LAT_LAST);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        o_ram_en   = 1'b0;
        o_tx_valid = 1'b0;
        o_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = (count_clamped == '0) ? ST_FIN : ST_ISSUE;
            end
            ST_ISSUE: begin
                o_ram_en = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_done) state_d = ST_SEND;
            end
            ST_SEND: begin
                o_tx_valid = 1'b1;
                if (xfer && last_byte) state_d = last_word ? ST_FIN : ST_ISSUE;
            end
            ST_FIN: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            remain_q <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_q   <= i_base_addr;
                        remain_q <= count_clamped;
                        busy_q   <= 1'b1;
                    end
                end
                ST_ISSUE: wait_q <= '0;
                ST_WAIT: begin
                    // RAM output is settled here; zero-extend to pad the top byte.
                    if (lat_done) begin
                        shift_q <= SH_W'(i_ram_data);
                        byte_q  <= '0;
                    end else begin
                        wait_q <= wait_q + LAT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        shift_q <= shift_q >> 8;
                        byte_q  <= byte_q + BIDX_W'(1);
                        if (last_byte) begin
                            remain_q <= remain_q - ONE_WORD;
                            if (!last_word) addr_q <= addr_next;
                        end
                    end
                end
                ST_FIN: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_ram_addr = addr_q;
    assign o_tx_data  = shift_q[7:0];
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_ram_datos_dump_reader.sv
// Directed bench: two readers (1- and 2-cycle read latency) against behavioural
// data-RAM models preloaded with BRAM[i] = i + 128.
module tb_ram_datos_dump_reader;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        rst_n = 1'b0;
    logic        tx_ready = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [9:0]  base1 = '0, base2 = '0;
    logic [10:0] count1 = '0, count2 = '0;
    logic [9:0]  addr1, addr2;
    logic        en1, en2;
    logic [15:0] douta1 = '0, douta2 = '0, hp_reg = '0;
    logic [7:0]  txd1, txd2;
    logic        v1, v2, busy1, busy2, done1, done2;

    logic [15:0] bram [1024];
    initial for (int i = 0; i < 1024; i++) bram[i] = 16'(i + 128);

    // LOW_LATENCY RAM: output updates on the read negedge.
    always @(negedge clka) if (en1) douta1 <= bram[addr1];
    // HIGH_PERFORMANCE RAM: extra output register stage.
    always @(negedge clka) begin
        if (en2) hp_reg <= bram[addr2];
        douta2 <= hp_reg;
    end

    ram_datos_dump_reader #(.RAM_WIDTH(16), .RAM_DEPTH(1024), .READ_LATENCY(1)) dut1 (
        .clka(clka), .rst_n(rst_n), .i_start(start1), .i_base_addr(base1), .i_count(count1),
        .o_ram_addr(addr1), .o_ram_en(en1), .i_ram_data(douta1), .o_tx_data(txd1),
        .o_tx_valid(v1), .i_tx_ready(tx_ready), .o_busy(busy1), .o_done(done1));

    ram_datos_dump_reader #(.RAM_WIDTH(16), .RAM_DEPTH(1024), .READ_LATENCY(2)) dut2 (
        .clka(clka), .rst_n(rst_n), .i_start(start2), .i_base_addr(base2), .i_count(count2),
        .o_ram_addr(addr2), .o_ram_en(en2), .i_ram_data(douta2), .o_tx_data(txd2),
        .o_tx_valid(v2), .i_tx_ready(tx_ready), .o_busy(busy2), .o_done(done2));

    // Byte/event monitor: valid&ready at negedge means a transfer at the next posedge.
    logic [7:0] rx1 [$];
    logic [7:0] rx2 [$];
    int done_cnt1 = 0, en_cnt1 = 0, v_cnt1 = 0, en_cnt2 = 0;
    always @(negedge clka) begin
        if (v1 && tx_ready) rx1.push_back(txd1);
        if (v2 && tx_ready) rx2.push_back(txd2);
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (en1)   en_cnt1   <= en_cnt1 + 1;
        if (v1)    v_cnt1    <= v_cnt1 + 1;
        if (en2)   en_cnt2   <= en_cnt2 + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [9:0] b, input logic [10:0] c);
        @(posedge clka); #1;
        start1 = 1'b1; base1 = b; count1 = c;
        @(posedge clka); #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            @(negedge clka);
            if (done1) seen = 1'b1;
            n++;
        end
        chk({name, " done"}, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic [9:0]  base;
        logic [10:0] count;
        bit          stall;
        bit          restart;
        int          nexp;
        logic [7:0]  exp [6];
        logic [9:0]  last_addr;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v, input string name);
        int  q0, d0, n;
        bit  seen, stable;
        q0 = rx1.size();
        d0 = done_cnt1;
        tx_ready = !v.stall;
        pulse_start(v.base, v.count);
        if (v.restart) begin
            repeat (2) @(posedge clka);
            #1; start1 = 1'b1; base1 = 10'd0; count1 = 11'd1;
            @(posedge clka); #1; start1 = 1'b0;
        end
        if (v.stall) begin
            n = 0; seen = 1'b0;
            while (n < 20 && !seen) begin
                @(negedge clka);
                seen = v1;
                n++;
            end
            chk({name, " valid seen"}, 32'(seen), 32'd1);
            stable = 1'b1;
            repeat (7) begin
                @(negedge clka);
                if (!v1 || txd1 !== v.exp[0]) stable = 1'b0;
            end
            chk({name, " stall stable"}, 32'(stable), 32'd1);
            @(posedge clka); #1; tx_ready = 1'b1;
        end
        wait_done(name, 200);
        @(negedge clka);
        chk({name, " busy low"}, 32'(busy1), 32'd0);
        @(negedge clka);
        chk({name, " nbytes"}, 32'(rx1.size() - q0), 32'(v.nexp));
        for (int i = 0; i < v.nexp; i++)
            if (q0 + i < rx1.size())
                chk($sformatf("%s byte%0d", name, i), 32'(rx1[q0 + i]), 32'(v.exp[i]));
        chk({name, " done pulses"}, 32'(done_cnt1 - d0), 32'd1);
        chk({name, " addr hold"}, 32'(addr1), 32'(v.last_addr));
    endtask

    initial begin
        int q0, e0, vc0, n;
        bit seen;

        vecs[0] = '{base: 10'd0,    count: 11'd2, stall: 1'b0, restart: 1'b0, nexp: 4,
                    exp: '{8'h80, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00}, last_addr: 10'd1};
        // 1023+128 = 0x047F, then wraps to words 0 and 1.
        vecs[1] = '{base: 10'd1023, count: 11'd3, stall: 1'b0, restart: 1'b0, nexp: 6,
                    exp: '{8'h7F, 8'h04, 8'h80, 8'h00, 8'h81, 8'h00}, last_addr: 10'd1};
        vecs[2] = '{base: 10'd5,    count: 11'd1, stall: 1'b1, restart: 1'b0, nexp: 2,
                    exp: '{8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, last_addr: 10'd5};
        vecs[3] = '{base: 10'd2,    count: 11'd2, stall: 1'b0, restart: 1'b1, nexp: 4,
                    exp: '{8'h82, 8'h00, 8'h83, 8'h00, 8'h00, 8'h00}, last_addr: 10'd3};
        // 1000+128 = 0x0468.
        vecs[4] = '{base: 10'd1000, count: 11'd1, stall: 1'b0, restart: 1'b0, nexp: 2,
                    exp: '{8'h68, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, last_addr: 10'd1000};
        vecs[5] = '{base: 10'd3,    count: 11'd1, stall: 1'b0, restart: 1'b0, nexp: 2,
                    exp: '{8'h83, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, last_addr: 10'd3};

        // Reset state
        #2;
        chk("rst valid", 32'(v1), 32'd0);
        chk("rst busy",  32'(busy1), 32'd0);
        chk("rst en",    32'(en1), 32'd0);
        chk("rst done",  32'(done1), 32'd0);
        chk("rst addr",  32'(addr1), 32'd0);
        chk("rst data",  32'(txd1), 32'd0);
        repeat (2) @(posedge clka);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Zero-length dump: straight to FIN, no RAM read, no bytes.
        e0 = en_cnt1; vc0 = v_cnt1;
        @(posedge clka); #1;
        start1 = 1'b1; base1 = 10'd7; count1 = 11'd0;
        @(negedge clka);
        chk("cnt0 done early", 32'(done1), 32'd0);
        @(posedge clka); #1; start1 = 1'b0;
        @(negedge clka);
        chk("cnt0 done", 32'(done1), 32'd1);
        chk("cnt0 busy in fin", 32'(busy1), 32'd1);
        @(negedge clka);
        chk("cnt0 done one cycle", 32'(done1), 32'd0);
        chk("cnt0 busy after", 32'(busy1), 32'd0);
        @(negedge clka);
        chk("cnt0 no en", 32'(en_cnt1 - e0), 32'd0);
        chk("cnt0 no valid", 32'(v_cnt1 - vc0), 32'd0);

        // Asynchronous reset mid-dump, then a clean dump afterwards.
        tx_ready = 1'b0;
        pulse_start(10'd0, 11'd2);
        n = 0; seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clka);
            seen = v1;
            n++;
        end
        chk("arst valid seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid", 32'(v1), 32'd0);
        chk("arst busy",  32'(busy1), 32'd0);
        chk("arst en",    32'(en1), 32'd0);
        @(posedge clka); #1 rst_n = 1'b1;
        run_vec(vecs[5], "post-rst");

        // Oversized count is clamped to the full RAM depth.
        q0 = rx1.size();
        pulse_start(10'd0, 11'h7FF);
        wait_done("clamp", 9000);
        repeat (2) @(negedge clka);
        chk("clamp nbytes", 32'(rx1.size() - q0), 32'd2048);
        if (rx1.size() >= q0 + 2048) begin
            chk("clamp first", 32'(rx1[q0]), 32'h80);
            chk("clamp last lo", 32'(rx1[q0 + 2046]), 32'h7F);
            chk("clamp last hi", 32'(rx1[q0 + 2047]), 32'h04);
        end
        chk("clamp addr", 32'(addr1), 32'd1023);

        // Two-cycle read latency with a registered-output RAM.
        q0 = rx2.size(); e0 = en_cnt2;
        @(posedge clka); #1;
        start2 = 1'b1; base2 = 10'd0; count2 = 11'd2;
        @(posedge clka); #1; start2 = 1'b0;
        n = 0; seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clka);
            if (done2) seen = 1'b1;
            n++;
        end
        chk("rl2 done", 32'(seen), 32'd1);
        repeat (2) @(negedge clka);
        chk("rl2 busy low", 32'(busy2), 32'd0);
        chk("rl2 nbytes", 32'(rx2.size() - q0), 32'd4);
        if (rx2.size() >= q0 + 4) begin
            chk("rl2 byte0", 32'(rx2[q0]),     32'h80);
            chk("rl2 byte1", 32'(rx2[q0 + 1]), 32'h00);
            chk("rl2 byte2", 32'(rx2[q0 + 2]), 32'h81);
            chk("rl2 byte3", 32'(rx2[q0 + 3]), 32'h00);
        end
        chk("rl2 reads", 32'(en_cnt2 - e0), 32'd2);
        chk("rl2 idle valid", 32'(v2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
